// File: rtl/layer_engine_if.sv
// Streaming interface of the layer engine: scalar input samples in,
// scalar output samples out, each with a valid/ready handshake.
interface layer_engine_if #(
  parameter int BIT_SIZE = 16
) ();
  logic                x_valid;
  logic                x_ready;
  logic [BIT_SIZE-1:0] x;
  logic                y_valid;
  logic                y_ready;
  logic [BIT_SIZE-1:0] y;
  logic                y_last;

  modport master (
    output x_valid, x, y_ready,
    input  x_ready, y_valid, y, y_last
  );

  modport slave (
    input  x_valid, x, y_ready,
    output x_ready, y_valid, y, y_last
  );
endinterface

// File: rtl/layer_engine.sv
// Multi-layer fixed-point fully connected engine: loads an input vector,
// runs up to LAYER_DEPTH layers in place over one buffer, then streams it out.
module layer_engine #(
  parameter int BIT_SIZE    = 16,
  parameter int LAYER_SIZE  = 4,
  parameter int LAYER_DEPTH = 4,
  parameter int FRAC_BITS   = 8,
  parameter int ACC_SIZE    = 2*BIT_SIZE + $clog2(LAYER_SIZE)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               w_write,
  input  logic [$clog2(LAYER_DEPTH)-1:0]     w_layer,
  input  logic [$clog2(LAYER_SIZE)-1:0]      w_node,
  input  logic [LAYER_SIZE*BIT_SIZE-1:0]     w_in,
  input  logic [$clog2(LAYER_DEPTH):0]       num_layers,
  input  logic                               relu_en,
  layer_engine_if.slave                      io,
  output logic                               busy
);

  localparam int LW  = $clog2(LAYER_DEPTH);
  localparam int NW  = $clog2(LAYER_SIZE);
  localparam int CW  = $clog2(LAYER_SIZE + 1);
  localparam int PW  = 2*BIT_SIZE;
  localparam int EXT = ACC_SIZE - PW;

  localparam logic signed [ACC_SIZE-1:0] SAT_MAX =
    {{(ACC_SIZE-BIT_SIZE+1){1'b0}}, {(BIT_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] SAT_MIN =
    {{(ACC_SIZE-BIT_SIZE+1){1'b1}}, {(BIT_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

  state_t state, state_next;

  logic [LAYER_SIZE*BIT_SIZE-1:0] w_mem [LAYER_DEPTH][LAYER_SIZE];
  logic [LAYER_SIZE*BIT_SIZE-1:0] rd_row;

  logic signed [BIT_SIZE-1:0] data_buf [LAYER_SIZE];
  logic signed [ACC_SIZE-1:0] acc      [LAYER_SIZE];
  logic signed [ACC_SIZE-1:0] shifted  [LAYER_SIZE];
  logic signed [BIT_SIZE-1:0] act      [LAYER_SIZE];
  logic [PW-1:0]              wide_w   [LAYER_SIZE];
  logic [PW-1:0]              prod     [LAYER_SIZE];
  logic signed [ACC_SIZE-1:0] prod_ext [LAYER_SIZE];
  logic [PW-1:0]              wide_x;

  logic [NW-1:0] in_idx;
  logic [NW-1:0] out_idx;
  logic [NW-1:0] mac_sel;
  logic [CW-1:0] cnt;
  logic [LW-1:0] layer;
  logic [LW-1:0] last_layer;
  logic [LW:0]   nl_eff;
  logic          relu_s;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    io.x_ready = 1'b0;
    io.y_valid = 1'b0;
    io.y       = '0;
    io.y_last  = 1'b0;
    case (state)
      IDLE: begin
        io.x_ready = 1'b1;
        if (io.x_valid && in_idx == NW'(LAYER_SIZE-1)) state_next = MAC;
      end
      MAC: begin
        if (cnt == CW'(LAYER_SIZE)) state_next = ACT;
      end
      ACT: begin
        state_next = (layer == last_layer) ? OUT : MAC;
      end
      OUT: begin
        io.y_valid = 1'b1;
        io.y       = data_buf[out_idx];
        io.y_last  = (out_idx == NW'(LAYER_SIZE-1));
        if (io.y_ready && out_idx == NW'(LAYER_SIZE-1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Layer count is sampled with the first sample: 0 means one layer, excess clamps.
  always_comb begin
    if (num_layers == '0)
      nl_eff = (LW+1)'(1);
    else if (num_layers > (LW+1)'(LAYER_DEPTH))
      nl_eff = (LW+1)'(LAYER_DEPTH);
    else
      nl_eff = num_layers;
  end

  // Read data lags the issued index by one cycle, so the multiplier uses cnt-1.
  always_comb begin
    mac_sel = NW'(cnt - 1'b1);
    wide_x  = {{BIT_SIZE{data_buf[mac_sel][BIT_SIZE-1]}}, data_buf[mac_sel]};
    for (int j = 0; j < LAYER_SIZE; j++) begin
      wide_w[j]   = {{BIT_SIZE{rd_row[j*BIT_SIZE+BIT_SIZE-1]}},
                     rd_row[j*BIT_SIZE +: BIT_SIZE]};
      prod[j]     = wide_w[j] * wide_x;
      prod_ext[j] = {{EXT{prod[j][PW-1]}}, prod[j]};
    end
  end

  always_comb begin
    for (int j = 0; j < LAYER_SIZE; j++) begin
      shifted[j] = acc[j] >>> FRAC_BITS;
      act[j]     = shifted[j][BIT_SIZE-1:0];
      if (shifted[j] > SAT_MAX)
        act[j] = SAT_MAX[BIT_SIZE-1:0];
      else if (shifted[j] < SAT_MIN)
        act[j] = SAT_MIN[BIT_SIZE-1:0];
      if (relu_s && layer != last_layer && act[j][BIT_SIZE-1])
        act[j] = '0;
    end
  end

  // Weight store is never reset; writes are locked out while a vector is in flight.
  always_ff @(posedge clk) begin
    if (w_write && !busy) w_mem[w_layer][w_node] <= w_in;
    rd_row <= w_mem[layer][cnt[NW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx     <= '0;
      out_idx    <= '0;
      cnt        <= '0;
      layer      <= '0;
      last_layer <= '0;
      relu_s     <= 1'b0;
      busy       <= 1'b0;
      for (int j = 0; j < LAYER_SIZE; j++) begin
        acc[j]      <= '0;
        data_buf[j] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          layer <= '0;
          if (io.x_valid) begin
            data_buf[in_idx] <= io.x;
            in_idx <= (in_idx == NW'(LAYER_SIZE-1)) ? '0 : in_idx + 1'b1;
            if (in_idx == '0) begin
              busy       <= 1'b1;
              last_layer <= LW'(nl_eff - 1'b1);
              relu_s     <= relu_en;
            end
          end
        end
        MAC: begin
          cnt <= cnt + 1'b1;
          for (int j = 0; j < LAYER_SIZE; j++) begin
            if (cnt == '0) acc[j] <= '0;
            else           acc[j] <= acc[j] + prod_ext[j];
          end
        end
        ACT: begin
          cnt <= '0;
          for (int j = 0; j < LAYER_SIZE; j++) data_buf[j] <= act[j];
          if (layer != last_layer) layer <= layer + 1'b1;
        end
        OUT: begin
          if (io.y_ready) begin
            if (out_idx == NW'(LAYER_SIZE-1)) begin
              out_idx <= '0;
              busy    <= 1'b0;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_engine.sv
// Bench for layer_engine: table of vectors with a scoreboard queue of expected
// outputs, plus hand sequences for reset abort and weight-write lockout.
module tb_layer_engine;

  localparam int B  = 16;
  localparam int LS = 4;

  typedef struct {
    int              cfg;
    int              nl;
    bit              relu;
    logic [3:0][15:0] xs;
    logic [3:0][15:0] ys;
    int              lat;
    int              stall;
    bit              wr_busy;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             w_write;
  logic [1:0]       w_layer;
  logic [1:0]       w_node;
  logic [LS*B-1:0]  w_in;
  logic [2:0]       num_layers;
  logic             relu_en;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  vec_t vecs[11];

  layer_engine_if #(.BIT_SIZE(B)) io ();

  layer_engine dut (
    .clk(clk), .rst(rst), .w_write(w_write), .w_layer(w_layer),
    .w_node(w_node), .w_in(w_in), .num_layers(num_layers),
    .relu_en(relu_en), .io(io), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input int cfg, input int nl, input bit relu,
                              input int x0, input int x1, input int x2, input int x3,
                              input int y0, input int y1, input int y2, input int y3,
                              input int lat, input int stall, input bit wr);
    vec_t v;
    v.cfg = cfg; v.nl = nl; v.relu = relu;
    v.xs[0] = 16'(x0); v.xs[1] = 16'(x1); v.xs[2] = 16'(x2); v.xs[3] = 16'(x3);
    v.ys[0] = 16'(y0); v.ys[1] = 16'(y1); v.ys[2] = 16'(y2); v.ys[3] = 16'(y3);
    v.lat = lat; v.stall = stall; v.wr_busy = wr;
    return v;
  endfunction

  task automatic writeRow(input int l, input int i, input logic [LS*B-1:0] row);
    w_write = 1'b1; w_layer = 2'(l); w_node = 2'(i); w_in = row;
    tick();
    w_write = 1'b0;
  endtask

  task automatic writeDiag(input int l, input int val);
    logic [LS*B-1:0] row;
    for (int i = 0; i < LS; i++) begin
      row = '0;
      row[i*B +: B] = 16'(val);
      writeRow(l, i, row);
    end
  endtask

  task automatic writeAll(input int l, input int val);
    logic [B-1:0] w;
    w = 16'(val);
    for (int i = 0; i < LS; i++) writeRow(l, i, {LS{w}});
  endtask

  task automatic setWeights(input int cfg);
    case (cfg)
      0: writeDiag(0, 256);
      1: begin
        writeDiag(0, -256);
        for (int l = 1; l < 4; l++) writeDiag(l, 256);
      end
      2: writeAll(0, 32767);
      3: writeAll(0, -32768);
      4: writeDiag(0, 128);
      5: begin
        writeDiag(0, 256);
        writeDiag(1, -256);
      end
      default: ;
    endcase
  endtask

  task automatic sendSamples(input vec_t v);
    int n;
    num_layers = 3'(v.nl);
    relu_en    = v.relu;
    for (int k = 0; k < LS; k++) begin
      io.x       = v.xs[k];
      io.x_valid = 1'b1;
      n = 0;
      while (!io.x_ready && n < 100) begin
        tick();
        n++;
      end
      if (!io.x_ready) checkOutput("x_ready_timeout", 0, 1);
      tick();
    end
    io.x_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    int n;
    for (int k = 0; k < LS; k++) exp_q.push_back(int'($signed(v.ys[k])));
    io.y_ready = (v.stall == 0);
    sendSamples(v);
    lat = 0;
    if (v.wr_busy) begin
      tick(); lat++;
      checkOutput("busy_in_mac", int'(busy), 1);
      w_write = 1'b1; w_layer = 2'd0; w_node = 2'd0; w_in = '0;
      tick(); lat++;
      w_write = 1'b0;
    end
    while (!io.y_valid && lat < 400) begin
      tick();
      lat++;
    end
    checkOutput("latency", lat, v.lat);
    for (int s = 0; s < v.stall; s++) begin
      checkOutput("stall_y_valid", int'(io.y_valid), 1);
      checkOutput("stall_y_hold", int'($signed(io.y)), exp_q[0]);
      tick();
    end
    io.y_ready = 1'b1;
    for (int k = 0; k < LS; k++) begin
      n = 0;
      while (!io.y_valid && n < 100) begin
        tick();
        n++;
      end
      if (exp_q.size() != 0) begin
        checkOutput("y_value", int'($signed(io.y)), exp_q.pop_front());
        checkOutput("y_last", int'(io.y_last), int'(k == LS-1));
      end
      tick();
    end
    checkOutput("post_y_valid", int'(io.y_valid), 0);
    checkOutput("post_busy", int'(busy), 0);
    checkOutput("post_x_ready", int'(io.x_ready), 1);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = mk(0, 1, 0,  10,  20, -30,  40,   10,  20, -30,  40,  6, 0, 0);
    vecs[1]  = mk(1, 2, 1, 100,-100,  50, -50,    0, 100,   0,  50, 12, 0, 0);
    vecs[2]  = mk(1, 2, 0, 100,-100,  50, -50, -100, 100, -50,  50, 12, 0, 0);
    vecs[3]  = mk(2, 1, 0, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 6, 0, 0);
    vecs[4]  = mk(3, 1, 0, 32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768, 6, 0, 0);
    vecs[5]  = mk(4, 1, 0,   3,  -3,   1,  -1,    1,  -2,   0,  -1,  6, 0, 0);
    vecs[6]  = mk(0, 0, 0,  10,  20, -30,  40,   10,  20, -30,  40,  6, 0, 0);
    vecs[7]  = mk(1, 7, 0, 100,-100,  50, -50, -100, 100, -50,  50, 24, 0, 0);
    vecs[8]  = mk(5, 2, 1, 100,-100,  50, -50, -100,   0, -50,   0, 12, 0, 0);
    vecs[9]  = mk(0, 1, 0,  10,  20, -30,  40,   10,  20, -30,  40,  6, 5, 0);
    vecs[10] = mk(0, 1, 0,  10,  20, -30,  40,   10,  20, -30,  40,  6, 0, 1);

    rst = 1'b1; w_write = 1'b0; w_layer = '0; w_node = '0; w_in = '0;
    num_layers = 3'd1; relu_en = 1'b0;
    io.x_valid = 1'b0; io.x = '0; io.y_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_x_ready", int'(io.x_ready), 1);
    checkOutput("reset_y_valid", int'(io.y_valid), 0);
    checkOutput("reset_y", int'(io.y), 0);
    checkOutput("reset_y_last", int'(io.y_last), 0);
    checkOutput("reset_busy", int'(busy), 0);

    for (int t = 0; t < 11; t++) begin
      setWeights(vecs[t].cfg);
      applyStimulus(vecs[t]);
    end

    // The lockout write above must not have touched layer 0.
    applyStimulus(vecs[0]);

    $display("[TB] reset during MAC");
    v = vecs[0];
    io.y_ready = 1'b1;
    sendSamples(v);
    tick(); tick();
    checkOutput("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_y_valid", int'(io.y_valid), 0);
    checkOutput("abort_x_ready", int'(io.x_ready), 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput("abort_no_output", int'(io.y_valid), 0);
    end
    applyStimulus(vecs[0]);

    $display("[TB] idle write of zero row");
    writeRow(0, 0, '0);
    v = mk(0, 1, 0, 10, 20, -30, 40, 0, 20, -30, 40, 6, 0, 0);
    applyStimulus(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_engine.md
Name: layer_engine

Overview:
- Parametrised multi-layer successor to the single memory and layer pair.
- Holds weights for LAYER_DEPTH fully connected layers of LAYER_SIZE neurons.
- Accepts an input vector as a scalar stream, runs num_layers layers back to back by feeding results back into its input buffer, and streams the output vector.
- Adds a valid/ready handshake, fixed-point scaling, saturation and optional ReLU.

Parameters:
BIT_SIZE, 16, data/weight width, signed two's complement
LAYER_SIZE, 4, neurons per layer = inputs per layer
LAYER_DEPTH, 4, max layers stored
FRAC_BITS, 8, fractional bits of the Q format
ACC_SIZE, 2*BIT_SIZE+$clog2(LAYER_SIZE), accumulator width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
w_write  in  1  weight row write strobe
w_layer  in  $clog2(LAYER_DEPTH)  target layer of write
w_node  in  $clog2(LAYER_SIZE)  input index i of write
w_in  in  LAYER_SIZE*BIT_SIZE  row: slice j = weight input i -> neuron j
num_layers  in  $clog2(LAYER_DEPTH)+1  layers to run
relu_en  in  1  ReLU on hidden layers
x_valid  in  1  input sample valid
x_ready  out  1  engine accepts sample
x  in  BIT_SIZE  input sample
y_valid  out  1  output sample valid
y_ready  in  1  consumer accepts sample
y  out  BIT_SIZE  output sample
y_last  out  1  marks neuron LAYER_SIZE-1
busy  out  1  computation in progress

Behaviour:
- Reset, taking effect at the next edge: state IDLE, x_ready=1, y_valid=0, y=0, y_last=0, busy=0, accumulators and counters cleared. Weight memory is not cleared.
- Reset mid-operation aborts the computation and discards partial data.
- Handshake: a transfer occurs on an edge where valid&&ready. y and y_last are held stable while y_valid&&!y_ready.
- FSM states:
  - IDLE/LOAD: x_ready=1. Accepts LAYER_SIZE samples into buf[0..LAYER_SIZE-1].
  - On the first accepted sample: busy goes high, and num_layers and relu_en are sampled. num_layers=0 is treated as 1; values above LAYER_DEPTH are clamped to LAYER_DEPTH.
  - When the LAYER_SIZE-th sample is accepted, go to MAC with layer l=0.
  - MAC: x_ready=0. Weight memory has a 1-cycle synchronous read. Issue reads i=0..LAYER_SIZE-1 on consecutive cycles; acc[j] += w[l][i][j]*buf[i] on the following cycle, for all j in parallel. Accumulators are cleared on MAC entry. Duration LAYER_SIZE+1 cycles, then ACT.
  - ACT (1 cycle): r = acc>>>FRAC_BITS, arithmetic shift, floor rounding. Saturate to [-2^(BIT_SIZE-1), 2^(BIT_SIZE-1)-1]. If relu_en and l<num_layers-1, negative results become 0; the final layer never gets ReLU. Write buf[j]=r.
  - After ACT: if l<num_layers-1 then l++ and go to MAC, else go to OUT.
  - OUT: present buf[0..LAYER_SIZE-1] in order, one per handshake. y_last=1 on index LAYER_SIZE-1. After that handshake: y_valid=0, busy=0, state IDLE, x_ready=1.
- Latency: y_valid rises exactly num_layers*(LAYER_SIZE+2) cycles after the edge accepting the last x. Back-to-back vectors are allowed: the next vector may be accepted the cycle after the y_last handshake.
- Weight write: on an edge with w_write=1 and busy=0, store row w_in at (w_layer,w_node). w_write is ignored while busy=1.
- Weight read/write of the same address in the same cycle cannot occur, since writes are blocked while busy.
- Products are full 2*BIT_SIZE signed and sign-extended into ACC_SIZE. The accumulator never overflows for these widths.

Test Plan:
- Identity, 1 layer: write w[0][i][j]=256 if i==j else 0; num_layers=1; x=10,20,-30,40 -> y=10,20,-30,40, y_last on 40, first y_valid 6 cycles after last x.
- Two layers with ReLU: layer0 diagonal -256, layer1 diagonal 256; relu_en=1, num_layers=2; x=100,-100,50,-50 -> y=0,100,0,50, latency 12. With relu_en=0 -> y=-100,100,-50,50.
- Saturation: all weights 32767, x=32767 x4 -> all y=32767. Weights -32768 with the same x -> all y=-32768.
- Backpressure: identity test with y_ready=0 for 5 cycles when y_valid rises, then 1 -> y=10 held stable for the 5 cycles, all 4 outputs delivered in order, no duplicates.
- Reset mid-MAC: assert rst for 1 cycle during MAC -> next cycle busy=0, y_valid=0, x_ready=1. Rerunning the identity test gives the identical result (weights retained).
- Write while busy: during MAC write row w[0][0]=all 0 -> current and next identity run are unaffected. The same write while idle zeroes y[0] on the next run.
